// File: rtl/fsm_seq_ctrl_pkg.sv
// Shared types and constants for the pattern-detector sequencing controller.
package fsm_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SHIFT,
        DRAIN,
        DONE
    } seqState_e;

    // Width of the optional running hit total.
    localparam int STAT_W = 16;

    // Largest value an unsigned counter of the given width can hold.
    function automatic int cntMax(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/fsm_seq_ctrl_piso.sv
// Parallel-in / serial-out shift register, MSB presented first.
module fsm_seq_ctrl_piso #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [DATA_W-1:0] word_i,
    output logic              msb_o
);

    logic [DATA_W-1:0] shiftReg_q;

    // Load takes priority so a new word is never lost to a stray shift.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shiftReg_q <= '0;
        end else if (load_i) begin
            shiftReg_q <= word_i;
        end else if (shift_i) begin
            shiftReg_q <= {shiftReg_q[DATA_W-2:0], 1'b0};
        end
    end

    assign msb_o = shiftReg_q[DATA_W-1];

endmodule

// File: rtl/fsm_seq_ctrl.sv
// Sequencing controller: accepts a host word, clears the detector, shifts the
// word out MSB-first and counts detector hits over the shift + drain window.
// Optional: define FSM_SEQ_CTRL_STAT_EN to add the o_total_hits running total.
module fsm_seq_ctrl
    import fsm_seq_ctrl_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 4,
    parameter int DRAIN_CYC = 1
) (
    input  logic              i_sys_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_word,
    output logic              o_ready,
    input  logic              i_abort,
    output logic              o_det_clr,
    output logic              o_bit,
    output logic              o_bit_en,
    input  logic              i_detect,
    output logic [CNT_W-1:0]  o_match_cnt,
`ifdef FSM_SEQ_CTRL_STAT_EN
    output logic [STAT_W-1:0] o_total_hits,
`endif
    output logic              o_done
);

    localparam int               BIT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);
    localparam logic [1:0]       DRAIN_LAST = 2'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(cntMax(CNT_W));

    seqState_e         state_q;
    logic              ready_q;
    logic              detClr_q;
    logic              bit_q;
    logic              bitEn_q;
    logic              done_q;
    logic [CNT_W-1:0]  matchCnt_q;
    logic [CNT_W-1:0]  hitCnt_q;
    logic [CNT_W-1:0]  hitCnt_d;
    logic [BIT_W-1:0]  bitCnt_q;
    logic [1:0]        drainCnt_q;
    logic              accept;
    logic              emitBit;
    logic              goDone;
    logic              pisoMsb;

    fsm_seq_ctrl_piso #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk_i   (i_sys_clk),
        .rst_n_i (i_rst_n),
        .load_i  (accept),
        .shift_i (emitBit),
        .word_i  (i_word),
        .msb_o   (pisoMsb)
    );

    // Handshake, bit-emission, completion and saturating hit-count decisions.
    always_comb begin
        accept   = (state_q == IDLE) && i_valid && ready_q;
        emitBit  = !i_abort &&
                   ((state_q == CLR) || ((state_q == SHIFT) && (bitCnt_q != BIT_LAST)));
        goDone   = !i_abort &&
                   (((state_q == SHIFT) && (bitCnt_q == BIT_LAST) && (DRAIN_CYC == 0)) ||
                    ((state_q == DRAIN) && (drainCnt_q == DRAIN_LAST)));
        hitCnt_d = hitCnt_q;
        if (((state_q == SHIFT) || (state_q == DRAIN)) && i_detect && (hitCnt_q != CNT_MAX)) begin
            hitCnt_d = hitCnt_q + 1'b1;
        end
    end

    // Sequencer state, counters and every registered output.
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            ready_q    <= 1'b1;
            detClr_q   <= 1'b0;
            bit_q      <= 1'b0;
            bitEn_q    <= 1'b0;
            done_q     <= 1'b0;
            matchCnt_q <= '0;
            hitCnt_q   <= '0;
            bitCnt_q   <= '0;
            drainCnt_q <= '0;
        end else begin
            detClr_q <= 1'b0;
            done_q   <= 1'b0;
            hitCnt_q <= hitCnt_d;
            bitEn_q  <= emitBit;
            bit_q    <= emitBit ? pisoMsb : 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q  <= CLR;
                        ready_q  <= 1'b0;
                        detClr_q <= 1'b1;
                        hitCnt_q <= '0;
                    end
                end
                CLR: begin
                    if (i_abort) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        state_q  <= SHIFT;
                        bitCnt_q <= '0;
                    end
                end
                SHIFT: begin
                    if (i_abort) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end else if (bitCnt_q == BIT_LAST) begin
                        state_q    <= (DRAIN_CYC == 0) ? DONE : DRAIN;
                        drainCnt_q <= '0;
                    end else begin
                        bitCnt_q <= bitCnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (i_abort) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end else if (drainCnt_q == DRAIN_LAST) begin
                        state_q <= DONE;
                    end else begin
                        drainCnt_q <= drainCnt_q + 2'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
            if (goDone) begin
                done_q     <= 1'b1;
                matchCnt_q <= hitCnt_d;
            end
        end
    end

`ifdef FSM_SEQ_CTRL_STAT_EN
    localparam int SUM_W = STAT_W + 1;

    logic [STAT_W-1:0] totalHits_q;
    logic [SUM_W-1:0]  totalSum;

    assign totalSum = {1'b0, totalHits_q} + SUM_W'(hitCnt_d);

    // Running total of completed-word counts, saturating at all-ones.
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            totalHits_q <= '0;
        end else if (goDone) begin
            totalHits_q <= totalSum[STAT_W] ? '1 : totalSum[STAT_W-1:0];
        end
    end

    assign o_total_hits = totalHits_q;
`endif

    assign o_ready     = ready_q;
    assign o_det_clr   = detClr_q;
    assign o_bit       = bit_q;
    assign o_bit_en    = bitEn_q;
    assign o_done      = done_q;
    assign o_match_cnt = matchCnt_q;

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Self-checking bench for fsm_seq_ctrl. Instance A uses the default
// parameters (DATA_W=8, CNT_W=4, DRAIN_CYC=1); instance B uses CNT_W=3 and
// DRAIN_CYC=0 so counter saturation and the no-drain path are exercised.
module tb_fsm_seq_ctrl;

    localparam time PERIOD = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       validA;
    logic       validB;
    logic       abortIn;
    logic       detectIn;
    logic [7:0] wordIn;

    logic       readyA, detClrA, bitA, bitEnA, doneA;
    logic       readyB, detClrB, bitB, bitEnB, doneB;
    logic [3:0] matchA;
    logic [2:0] matchB;
`ifdef FSM_SEQ_CTRL_STAT_EN
    logic [15:0] totalA;
    logic [15:0] totalB;
    logic [15:0] obsTotal;
    int          totalModel [2];
`endif

    int   checks   = 0;
    int   failures = 0;
    bit   selB     = 1'b0;
    int   lastCnt [2];
    time  lastDoneTime = 0;
    time  prevDoneTime = 0;

    // Observed status vector {ready, det_clr, bit, bit_en, done} of the instance under test
    logic [4:0] obsVec;
    logic [4:0] vecA;
    logic [4:0] vecB;
    logic [3:0] obsMatch;

    always #(PERIOD / 2) clk = ~clk;

    fsm_seq_ctrl #(
        .DATA_W    (8),
        .CNT_W     (4),
        .DRAIN_CYC (1)
    ) dutA (
        .i_sys_clk   (clk),
        .i_rst_n     (rst_n),
        .i_valid     (validA),
        .i_word      (wordIn),
        .o_ready     (readyA),
        .i_abort     (abortIn),
        .o_det_clr   (detClrA),
        .o_bit       (bitA),
        .o_bit_en    (bitEnA),
        .i_detect    (detectIn),
        .o_match_cnt (matchA),
`ifdef FSM_SEQ_CTRL_STAT_EN
        .o_total_hits(totalA),
`endif
        .o_done      (doneA)
    );

    fsm_seq_ctrl #(
        .DATA_W    (8),
        .CNT_W     (3),
        .DRAIN_CYC (0)
    ) dutB (
        .i_sys_clk   (clk),
        .i_rst_n     (rst_n),
        .i_valid     (validB),
        .i_word      (wordIn),
        .o_ready     (readyB),
        .i_abort     (abortIn),
        .o_det_clr   (detClrB),
        .o_bit       (bitB),
        .o_bit_en    (bitEnB),
        .i_detect    (detectIn),
        .o_match_cnt (matchB),
`ifdef FSM_SEQ_CTRL_STAT_EN
        .o_total_hits(totalB),
`endif
        .o_done      (doneB)
    );

    // Route the selected instance onto the shared observation signals
    always_comb begin
        vecA     = {readyA, detClrA, bitA, bitEnA, doneA};
        vecB     = {readyB, detClrB, bitB, bitEnB, doneB};
        obsVec   = selB ? vecB : vecA;
        obsMatch = selB ? {1'b0, matchB} : matchA;
`ifdef FSM_SEQ_CTRL_STAT_EN
        obsTotal = selB ? totalB : totalA;
`endif
    end

    // Advance one clock and settle just past the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One counted comparison; failures are reported with tag, observed and expected
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic driveValid(input bit sel, input logic v);
        if (sel) validB = v;
        else     validA = v;
    endtask

    // Run one full word through the selected instance and check every cycle
    // against the reference: bits MSB-first, count = min(hits in window, max).
    task automatic applyStimulus(input bit sel, input logic [7:0] w, input logic [11:0] det,
                                 input bit keepValid, input logic [7:0] nextW, input bit abortOnAccept);
        int         drain;
        int         maxC;
        int         sum;
        int         expCnt;
        logic [4:0] exp;
        drain = sel ? 0 : 1;
        maxC  = sel ? 7 : 15;
        sum   = 0;
        for (int i = 0; i < 8 + drain; i++) sum += int'(det[i]);
        expCnt = (sum > maxC) ? maxC : sum;

        selB = sel;
        driveValid(sel, 1'b1);
        wordIn   = w;
        abortIn  = abortOnAccept;
        detectIn = 1'($urandom);
        tick();
        checkOutput("accept_clr", obsVec, 5'b01000);
        driveValid(sel, keepValid);
        wordIn   = keepValid ? nextW : 8'($urandom);
        abortIn  = 1'b0;
        detectIn = 1'($urandom);
        for (int i = 0; i < 8; i++) begin
            tick();
            exp = {1'b0, 1'b0, w[7-i], 1'b1, 1'b0};
            checkOutput("shift_bit", obsVec, exp);
            detectIn = det[i];
        end
        for (int d = 0; d < drain; d++) begin
            tick();
            checkOutput("drain_quiet", obsVec, 5'b00000);
            detectIn = det[8+d];
        end
        tick();
        checkOutput("done_pulse", obsVec, 5'b00001);
        checkOutput("match_cnt", obsMatch, expCnt);
        prevDoneTime = lastDoneTime;
        lastDoneTime = $time;
        lastCnt[sel] = expCnt;
`ifdef FSM_SEQ_CTRL_STAT_EN
        totalModel[sel] = (totalModel[sel] + expCnt > 65535) ? 65535 : totalModel[sel] + expCnt;
        checkOutput("total_hits", obsTotal, totalModel[sel]);
`endif
        detectIn = 1'($urandom);
        tick();
        checkOutput("idle_ready", obsVec, 5'b10000);
        checkOutput("match_hold", obsMatch, expCnt);
    endtask

    // Accept a word, then abort it abortAt cycles after the clear cycle
    task automatic runAbort(input bit sel, input logic [7:0] w, input int abortAt);
        bit sawDone;
        selB = sel;
        driveValid(sel, 1'b1);
        wordIn   = w;
        abortIn  = 1'b0;
        detectIn = 1'b0;
        tick();
        driveValid(sel, 1'b0);
        wordIn = 8'($urandom);
        for (int i = 0; i < abortAt; i++) begin
            detectIn = 1'($urandom);
            tick();
        end
        abortIn = 1'b1;
        tick();
        abortIn = 1'b0;
        checkOutput("abort_idle", obsVec, 5'b10000);
        sawDone = 1'b0;
        for (int i = 0; i < 14; i++) begin
            detectIn = 1'($urandom);
            tick();
            if (obsVec[0]) sawDone = 1'b1;
        end
        checkOutput("abort_no_done", sawDone, 0);
        checkOutput("abort_match_keep", obsMatch, lastCnt[sel]);
    endtask

    // Reset asserted in the middle of bit 4 must clear all outputs at once
    task automatic runResetMidShift(input logic [7:0] w);
        bit         sawDone;
        logic [4:0] exp;
        selB = 1'b0;
        driveValid(1'b0, 1'b1);
        wordIn  = w;
        abortIn = 1'b0;
        tick();
        driveValid(1'b0, 1'b0);
        repeat (5) tick();
        exp = {1'b0, 1'b0, w[3], 1'b1, 1'b0};
        checkOutput("pre_reset_bit4", obsVec, exp);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_async_vecA", vecA, 5'b10000);
        checkOutput("rst_async_matchA", matchA, 0);
        checkOutput("rst_async_vecB", vecB, 5'b10000);
        checkOutput("rst_async_matchB", matchB, 0);
`ifdef FSM_SEQ_CTRL_STAT_EN
        checkOutput("rst_total_A", totalA, 0);
`endif
        #2 rst_n = 1'b1;
        lastCnt[0] = 0;
        lastCnt[1] = 0;
`ifdef FSM_SEQ_CTRL_STAT_EN
        totalModel[0] = 0;
        totalModel[1] = 0;
`endif
        sawDone = 1'b0;
        for (int i = 0; i < 15; i++) begin
            detectIn = 1'($urandom);
            tick();
            if (doneA) sawDone = 1'b1;
        end
        checkOutput("rst_no_done", sawDone, 0);
    endtask

    // Directed sequence followed by a short randomized phase
    initial begin
        bit         sel;
        logic [7:0] w;
        rst_n    = 1'b0;
        validA   = 1'b0;
        validB   = 1'b0;
        abortIn  = 1'b0;
        detectIn = 1'b0;
        wordIn   = 8'h00;
        lastCnt[0] = 0;
        lastCnt[1] = 0;
`ifdef FSM_SEQ_CTRL_STAT_EN
        totalModel[0] = 0;
        totalModel[1] = 0;
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        checkOutput("reset_vecA", vecA, 5'b10000);
        checkOutput("reset_matchA", matchA, 0);
        checkOutput("reset_vecB", vecB, 5'b10000);
        checkOutput("reset_matchB", matchB, 0);

        $display("[TB] serialization of 8'hA5 with no hits");
        applyStimulus(1'b0, 8'hA5, 12'h000, 1'b0, 8'h00, 1'b0);

        $display("[TB] detect tied high: 9 hits over shift + drain");
        applyStimulus(1'b0, 8'h55, 12'hFFF, 1'b0, 8'h00, 1'b0);

        $display("[TB] back-to-back words with valid held high");
        applyStimulus(1'b0, 8'hFF, 12'($urandom), 1'b1, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 12'($urandom), 1'b0, 8'h00, 1'b0);
        checkOutput("b2b_done_spacing", 32'(lastDoneTime - prevDoneTime), 32'(12 * PERIOD));

        $display("[TB] abort at third shift cycle, then abort alongside accept");
        runAbort(1'b0, 8'($urandom), 3);
        applyStimulus(1'b0, 8'($urandom), 12'($urandom), 1'b0, 8'h00, 1'b1);

        $display("[TB] CNT_W=3, DRAIN_CYC=0 instance saturates at 7");
        applyStimulus(1'b1, 8'h3C, 12'hFFF, 1'b0, 8'h00, 1'b0);
        runAbort(1'b1, 8'($urandom), $urandom_range(0, 8));

        $display("[TB] randomized words on both instances");
        for (int n = 0; n < 10; n++) begin
            sel = 1'($urandom_range(0, 1));
            w   = 8'($urandom);
            if ($urandom_range(0, 3) == 0)
                runAbort(sel, w, sel ? $urandom_range(0, 8) : $urandom_range(0, 9));
            else
                applyStimulus(sel, w, 12'($urandom), 1'b0, 8'h00, 1'($urandom_range(0, 1)));
        end

        $display("[TB] reset during bit 4");
        runResetMidShift(8'($urandom));
        applyStimulus(1'b0, 8'($urandom), 12'($urandom), 1'b0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
